commit_trace_tx: RTL
====================

Name: commit_trace_tx

Overview:
- Retire-side trace transmitter for the single-cycle/pipelined processor.
- Samples one architectural commit per cycle from the writeback stage and classifies it (REG / LD / ST / STU / NOP-branch / HALT).
- Stamps each commit with an instruction number and a cycle number, buffers it in a small FIFO, and sends it out through a valid/ready port.
- The consumer is the trace bench or a debug port. On HALT the block drains the FIFO and then raises a sticky done flag.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2
CNT_W, 32, width of instruction-number and cycle counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
commit_valid  in  1  an instruction retires this cycle
commit_pc  in  16  PC of retiring instruction
commit_inst  in  16  instruction word
commit_regwrite  in  1  register file written
commit_wreg  in  3  destination register
commit_wdata  in  16  register write data
commit_memread  in  1  memory read
commit_memwrite  in  1  memory write
commit_memaddr  in  16  memory address
commit_memdata  in  16  memory write data
commit_halt  in  1  retiring instruction is HALT
stall  out  1  FIFO full; upstream must hold the commit
trc_valid  out  1  trace record available
trc_ready  in  1  consumer accepts record
trc_kind  out  3  0=NOP/BR 1=REG 2=LD 3=ST 4=STU 5=HALT
trc_inum  out  CNT_W  instruction number (first = 0)
trc_cycle  out  CNT_W  cycle of acceptance
trc_pc  out  16  record PC
trc_inst  out  16  record instruction
trc_reg  out  3  destination register
trc_rdata  out  16  register write data
trc_addr  out  16  memory address
trc_mdata  out  16  memory data
overflow  out  1  sticky: commit_valid was presented while stall=1
done  out  1  sticky: HALT record has been handed out

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, both counters = 0, state = RUN. All outputs are 0: stall, trc_valid, overflow, done, and all trc_* data.
- Cycle counter
  - Increments every cycle that rst=0; wraps at 2^CNT_W.
  - A record's trc_cycle is the counter value in its acceptance cycle. The first cycle after reset is 0.
- Accept condition: state==RUN && commit_valid && !stall.
- On accept:
  - Push the record and stamp it with the current inum.
  - inum then increments and wraps at 2^CNT_W.
- Classification, first match wins:
  - regwrite & memwrite → STU
  - regwrite & memread → LD
  - regwrite → REG
  - halt → HALT
  - memwrite → ST
  - otherwise → NOP/BR
- Field masking:
  - For kinds that do not carry a field, the field is forced to 0: trc_reg/rdata for ST, NOP, HALT; trc_addr for REG, NOP, HALT; trc_mdata for everything except ST and STU.
- FIFO timing and flow control
  - trc_valid = !empty, driven from registered FIFO state.
  - Latency: a commit accepted in cycle N is visible at trc_valid in cycle N+1.
  - There is no combinational path from commit_* to trc_*.
  - Pop happens when trc_valid && trc_ready.
  - trc_* must hold stable while trc_valid && !trc_ready.
- stall
  - stall = (count==DEPTH), from registered count only. There is no bypass: when the FIFO is full, a same-cycle pop does not allow a same-cycle push.
  - If commit_valid && stall, the commit is not accepted, inum does not advance, and overflow sets. overflow stays set until reset.
- Simultaneous push and pop when the FIFO is not full: count is unchanged and ordering is preserved.
- State machine
  - RUN: accepting a HALT record moves the block to DRAIN.
  - DRAIN: every commit_valid is ignored; it does not set overflow and inum stays frozen. When the pop of the HALT record occurs (it is always the last entry), the block moves to DONE.
  - DONE: done=1 and trc_valid=0. The block stays in DONE until rst.
- Reset mid-operation: all in-flight records are discarded and the block returns to the reset state on the next edge.

Test Plan:
- Reset, then one commit per cycle with trc_ready=1: REG (pc 0x0000, r3←0x1234), LD (pc 0x0002, r1←0xBEEF, addr 0x0040), STU (pc 0x0004, r2←0x0050, addr 0x0050, data 0x00AA) → records appear one cycle later with inum 0,1,2, cycle 0,1,2, kinds 1,2,4, and all fields exact.
- Hold trc_ready=0 and present 5 commits (DEPTH=4) → stall rises after the 4th accept, the 5th is not accepted and overflow=1. Then set trc_ready=1 → inum 0–3 are delivered in order and stall drops on the first pop.
- ST (pc 0x0010, addr 0x0100, data 0x5A5A) followed by a NOP/branch commit → kinds 3 and 0; ST has trc_reg=0 and trc_rdata=0; NOP has addr and mdata = 0.
- REG, then HALT at pc 0x0008, then two more commit_valid pulses with trc_ready=0 → HALT is inum 1, later commits are ignored and overflow stays 0. Release trc_ready → done=1 exactly one cycle after the HALT pop, and trc_valid=0 afterwards.
- Assert rst for one cycle with 3 records buffered and overflow=1 → the next cycle shows trc_valid=0, overflow=0, done=0; the next accepted commit has inum 0 and cycle 0.
- Simultaneous push and pop at count=2 for 10 cycles → count stays 2, with no reordering or loss (inum sequence contiguous).

Source files
------------

// File: rtl/commit_trace_tx.sv
// Retire-side trace transmitter: classifies each architectural commit, stamps it with
// instruction/cycle numbers, buffers it in a small FIFO and hands it out over valid/ready.
module commit_trace_tx #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [15:0]      commit_pc,
   input  logic [15:0]      commit_inst,
   input  logic             commit_regwrite,
   input  logic [2:0]       commit_wreg,
   input  logic [15:0]      commit_wdata,
   input  logic             commit_memread,
   input  logic             commit_memwrite,
   input  logic [15:0]      commit_memaddr,
   input  logic [15:0]      commit_memdata,
   input  logic             commit_halt,
   output logic             stall,
   output logic             trc_valid,
   input  logic             trc_ready,
   output logic [2:0]       trc_kind,
   output logic [CNT_W-1:0] trc_inum,
   output logic [CNT_W-1:0] trc_cycle,
   output logic [15:0]      trc_pc,
   output logic [15:0]      trc_inst,
   output logic [2:0]       trc_reg,
   output logic [15:0]      trc_rdata,
   output logic [15:0]      trc_addr,
   output logic [15:0]      trc_mdata,
   output logic             overflow,
   output logic             done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      K_NOP  = 3'd0,
      K_REG  = 3'd1,
      K_LD   = 3'd2,
      K_ST   = 3'd3,
      K_STU  = 3'd4,
      K_HALT = 3'd5
   } kind_e;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   typedef struct packed {
      kind_e            kind;
      logic [CNT_W-1:0] inum;
      logic [CNT_W-1:0] cycle;
      logic [15:0]      pc;
      logic [15:0]      inst;
      logic [2:0]       dreg;
      logic [15:0]      rdata;
      logic [15:0]      addr;
      logic [15:0]      mdata;
   } rec_t;

   rec_t             r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic [CNT_W-1:0] r_inum;
   logic [CNT_W-1:0] r_cycle;
   state_e           r_state;
   logic             r_overflow;
   logic             r_done;

   rec_t             w_rec;
   rec_t             w_head;
   logic             w_valid;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full  = (r_count == FULL);
   assign w_valid = (r_count != '0);
   assign w_push  = (r_state == S_RUN) && commit_valid && !w_full;
   assign w_pop   = w_valid && trc_ready;
   assign w_head  = r_mem[r_rd];

   // Classification priority: register-writing kinds win over halt, halt over plain store.
   always_comb begin
      w_rec       = '0;
      w_rec.inum  = r_inum;
      w_rec.cycle = r_cycle;
      w_rec.pc    = commit_pc;
      w_rec.inst  = commit_inst;
      if (commit_regwrite && commit_memwrite) begin
         w_rec.kind  = K_STU;
         w_rec.dreg  = commit_wreg;
         w_rec.rdata = commit_wdata;
         w_rec.addr  = commit_memaddr;
         w_rec.mdata = commit_memdata;
      end else if (commit_regwrite && commit_memread) begin
         w_rec.kind  = K_LD;
         w_rec.dreg  = commit_wreg;
         w_rec.rdata = commit_wdata;
         w_rec.addr  = commit_memaddr;
      end else if (commit_regwrite) begin
         w_rec.kind  = K_REG;
         w_rec.dreg  = commit_wreg;
         w_rec.rdata = commit_wdata;
      end else if (commit_halt) begin
         w_rec.kind  = K_HALT;
      end else if (commit_memwrite) begin
         w_rec.kind  = K_ST;
         w_rec.addr  = commit_memaddr;
         w_rec.mdata = commit_memdata;
      end else begin
         w_rec.kind  = K_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_rec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_inum     <= '0;
         r_cycle    <= '0;
         r_state    <= S_RUN;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_cycle <= r_cycle + CNT_W'(1);
         if (w_push) begin
            r_wr   <= r_wr + AW'(1);
            r_inum <= r_inum + CNT_W'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + ONE;
            2'b01:   r_count <= r_count - ONE;
            default: r_count <= r_count;
         endcase
         case (r_state)
            S_RUN: begin
               if (commit_valid && w_full) r_overflow <= 1'b1;
               if (w_push && w_rec.kind == K_HALT) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_pop && w_head.kind == K_HALT) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_DONE;
         endcase
      end
   end

   // Data outputs are zeroed while the FIFO is empty so stale entries never leak out.
   rec_t w_out;
   assign w_out     = w_valid ? w_head : '0;
   assign stall     = w_full;
   assign trc_valid = w_valid;
   assign trc_kind  = w_out.kind;
   assign trc_inum  = w_out.inum;
   assign trc_cycle = w_out.cycle;
   assign trc_pc    = w_out.pc;
   assign trc_inst  = w_out.inst;
   assign trc_reg   = w_out.dreg;
   assign trc_rdata = w_out.rdata;
   assign trc_addr  = w_out.addr;
   assign trc_mdata = w_out.mdata;
   assign overflow  = r_overflow;
   assign done      = r_done;

endmodule
